// File: rtl/krake_port_pkg.sv
// krake_port_pkg: shared definitions for the krake_port I/O peripheral.
// - bus/register widths
// - register address map
// - per-pin output source encodings
package krake_port_pkg;

  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PIN_CONF_W = 5;  // [2:0] source select, [4:3] reserved storage

  localparam logic [ADDR_W-1:0] PORT_CONF      = 5'h00;
  localparam logic [ADDR_W-1:0] PORT_STATUS    = 5'h01;
  localparam logic [ADDR_W-1:0] PORT_PIN0_CONF = 5'h02;
  localparam logic [ADDR_W-1:0] PORT_PIN1_CONF = 5'h03;
  localparam logic [ADDR_W-1:0] PORT_PIN2_CONF = 5'h04;
  localparam logic [ADDR_W-1:0] PORT_PIN3_CONF = 5'h05;
  localparam logic [ADDR_W-1:0] PORT_PIN4_CONF = 5'h06;
  localparam logic [ADDR_W-1:0] PORT_PIN5_CONF = 5'h07;

  // Select codes 5..7 are not listed and fall back to the GPIO value.
  typedef enum logic [2:0] {
    SRC_GPIO = 3'd0,
    SRC_CLKA = 3'd1,
    SRC_CLKB = 3'd2,
    SRC_CLKC = 3'd3,
    SRC_CLKD = 3'd4
  } src_e;

endpackage

// File: rtl/krake_pin_mux.sv
// krake_pin_mux: combinational output-source mux for one port channel.
// Ports:
//   sel_i   - source select (PORT_PINn_CONF[2:0])
//   gpio_i  - GPIO output value for this channel
//   clka_i..clkd_i - divided clock sources, treated as plain data
//   out_o   - selected pad output value
module krake_pin_mux
  import krake_port_pkg::*;
(
  input  logic [2:0] sel_i,
  input  logic       gpio_i,
  input  logic       clka_i,
  input  logic       clkb_i,
  input  logic       clkc_i,
  input  logic       clkd_i,
  output logic       out_o
);

  always_comb begin
    out_o = gpio_i;
    case (sel_i)
      SRC_CLKA: out_o = clka_i;
      SRC_CLKB: out_o = clkb_i;
      SRC_CLKC: out_o = clkc_i;
      SRC_CLKD: out_o = clkd_i;
      default:  out_o = gpio_i;
    endcase
  end

endmodule

// File: rtl/krake_port.sv
// krake_port: NCH-channel configurable I/O port on a Wishbone-style register bus.
// Ports:
//   clk_i, rst_i           - clock, synchronous active-low reset
//   stb_i, we_i, adr_i     - bus strobe, write enable, register address
//   dat_i / dat_o, ack_o   - write data / registered read data, registered ack
//   ch_in                  - pad input levels (2-FF synchronised, readable in PORT_STATUS)
//   ch_out, ch_oe          - pad output values and output enables
//   clka..clkd             - per-pin selectable output sources
module krake_port
  import krake_port_pkg::*;
#(
  parameter int unsigned NCH = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o,
  input  logic [NCH-1:0]    ch_in,
  output logic [NCH-1:0]    ch_out,
  output logic [NCH-1:0]    ch_oe,
  input  logic              clka,
  input  logic              clkb,
  input  logic              clkc,
  input  logic              clkd
);

  logic [NCH-1:0]        conf_q, conf_d;
  logic [NCH-1:0]        gpio_q, gpio_d;
  logic [PIN_CONF_W-1:0] pin_conf_q [NCH];
  logic [PIN_CONF_W-1:0] pin_conf_d [NCH];
  logic [NCH-1:0]        sync1_q, sync1_d;
  logic [NCH-1:0]        sync2_q, sync2_d;
  logic [DATA_W-1:0]     dat_q, dat_d;
  logic                  ack_q, ack_d;
  logic [DATA_W-1:0]     rd_data;

  // Upper write-data bits have no storage behind them.
  logic unused_dat;
  assign unused_dat = ^dat_i[DATA_W-1:NCH];

  always_comb begin
    conf_d     = conf_q;
    gpio_d     = gpio_q;
    pin_conf_d = pin_conf_q;
    dat_d      = dat_q;
    ack_d      = stb_i;
    sync1_d    = ch_in;
    sync2_d    = sync1_q;

    // Unmapped addresses read as zero.
    rd_data = '0;
    if (adr_i == PORT_CONF)   rd_data = DATA_W'(conf_q);
    if (adr_i == PORT_STATUS) rd_data = DATA_W'(sync2_q);
    for (int unsigned i = 0; i < NCH; i++) begin
      if (adr_i == ADDR_W'(PORT_PIN0_CONF + i)) rd_data = DATA_W'(pin_conf_q[i]);
    end

    if (stb_i) begin
      if (we_i) begin
        if (adr_i == PORT_CONF)   conf_d = dat_i[NCH-1:0];
        if (adr_i == PORT_STATUS) gpio_d = dat_i[NCH-1:0];
        for (int unsigned i = 0; i < NCH; i++) begin
          if (adr_i == ADDR_W'(PORT_PIN0_CONF + i)) pin_conf_d[i] = dat_i[PIN_CONF_W-1:0];
        end
      end else begin
        dat_d = rd_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      conf_q     <= '0;
      gpio_q     <= '0;
      pin_conf_q <= '{default: '0};
      sync1_q    <= '0;
      sync2_q    <= '0;
      dat_q      <= '0;
      ack_q      <= 1'b0;
    end else begin
      conf_q     <= conf_d;
      gpio_q     <= gpio_d;
      pin_conf_q <= pin_conf_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign ch_oe = conf_q;

  for (genvar n = 0; n < NCH; n++) begin : g_pin
    krake_pin_mux u_mux (
      .sel_i  (pin_conf_q[n][2:0]),
      .gpio_i (gpio_q[n]),
      .clka_i (clka),
      .clkb_i (clkb),
      .clkc_i (clkc),
      .clkd_i (clkd),
      .out_o  (ch_out[n])
    );
  end

endmodule

// File: tb/tb_krake_port.sv
// tb_krake_port: self-checking bench for krake_port with a register-map level
// reference model (stored register contents plus the last two sampled pin levels).
module tb_krake_port;
  import krake_port_pkg::*;

  localparam int NCH = 6;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              stb_i = 1'b0;
  logic              we_i  = 1'b0;
  logic [ADDR_W-1:0] adr_i = '0;
  logic [DATA_W-1:0] dat_i = '0;
  logic [DATA_W-1:0] dat_o;
  logic              ack_o;
  logic [NCH-1:0]    ch_in;
  logic [NCH-1:0]    ch_out;
  logic [NCH-1:0]    ch_oe;
  logic              clka = 1'b0, clkb = 1'b0, clkc = 1'b0, clkd = 1'b0;

  logic              loop_en   = 1'b0;
  logic              rand_in   = 1'b0;
  logic [NCH-1:0]    ch_in_drv = '0;
  assign ch_in = loop_en ? ch_out : ch_in_drv;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [NCH-1:0]        m_conf, m_gpio;
  logic [PIN_CONF_W-1:0] m_pin [NCH];
  logic [DATA_W-1:0]     m_dat;
  logic                  m_ack;
  logic [NCH-1:0]        h_last, h_prev;  // pin levels seen at the previous two edges

  krake_port #(.NCH(NCH)) dut (
    .clk_i (clk_i), .rst_i (rst_i), .stb_i (stb_i), .we_i (we_i),
    .adr_i (adr_i), .dat_i (dat_i), .dat_o (dat_o), .ack_o (ack_o),
    .ch_in (ch_in), .ch_out (ch_out), .ch_oe (ch_oe),
    .clka (clka), .clkb (clkb), .clkc (clkc), .clkd (clkd)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    int ai = int'(a);
    if (ai == 0) return {2'b00, m_conf};
    if (ai == 1) return {2'b00, h_prev};
    if (ai >= 2 && ai <= 7) return {3'b000, m_pin[ai-2]};
    return 8'h00;
  endfunction

  function automatic logic [NCH-1:0] exp_out();
    logic [NCH-1:0] r;
    r = '0;
    for (int n = 0; n < NCH; n++) begin
      case (int'(m_pin[n][2:0]))
        1:       r[n] = clka;
        2:       r[n] = clkb;
        3:       r[n] = clkc;
        4:       r[n] = clkd;
        default: r[n] = m_gpio[n];
      endcase
    end
    return r;
  endfunction

  // One clock cycle: drive inputs at negedge, advance the model, return #1 after posedge.
  task automatic cyc(input logic stb, input logic we, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d);
    int ai;
    @(negedge clk_i);
    stb_i = stb; we_i = we; adr_i = a; dat_i = d;
    {clka, clkb, clkc, clkd} = 4'($urandom);
    if (rand_in) ch_in_drv = NCH'($urandom);
    #1;
    ai = int'(a);
    if (!rst_i) begin
      m_conf = '0; m_gpio = '0; m_dat = '0; m_ack = 1'b0;
      h_last = '0; h_prev = '0;
      for (int n = 0; n < NCH; n++) m_pin[n] = '0;
    end else begin
      m_ack = stb;
      if (stb && !we) m_dat = model_read(a);
      if (stb && we) begin
        if (ai == 0) m_conf = d[NCH-1:0];
        else if (ai == 1) m_gpio = d[NCH-1:0];
        else if (ai >= 2 && ai <= 7) m_pin[ai-2] = d[PIN_CONF_W-1:0];
      end
      h_prev = h_last;
      h_last = ch_in;
    end
    @(posedge clk_i);
    #1;
    stb_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; loop_en = 1'b0; rand_in = 1'b0; ch_in_drv = '0;
    repeat (3) cyc(1'b0, 1'b0, '0, '0);
    rst_i = 1'b1;
    n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", ack_o); end
    n_cmp++; if (dat_o !== 8'h00) begin n_bad++; $display("FAIL reset_dat: got %h want 00", dat_o); end
    n_cmp++; if (ch_oe !== 6'h00) begin n_bad++; $display("FAIL reset_oe: got %h want 00", ch_oe); end
    n_cmp++; if (ch_out !== 6'h00) begin n_bad++; $display("FAIL reset_out: got %h want 00", ch_out); end
    for (int a = 0; a < 8; a++) begin
      cyc(1'b1, 1'b0, ADDR_W'(a), 8'hA5);
      n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL reset_rd_ack[%0d]: got %b want 1", a, ack_o); end
      n_cmp++; if (dat_o !== 8'h00) begin n_bad++; $display("FAIL reset_rd_dat[%0d]: got %h want 00", a, dat_o); end
    end
    cyc(1'b0, 1'b0, '0, '0);
    n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL idle_ack: got %b want 0", ack_o); end
  endtask

  task automatic test_conf();
    cyc(1'b1, 1'b1, PORT_CONF, 8'hFF);
    n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL conf_wr_ack: got %b want 1", ack_o); end
    n_cmp++; if (ch_oe !== 6'h3F) begin n_bad++; $display("FAIL conf_oe: got %h want 3f", ch_oe); end
    n_cmp++; if (dat_o !== m_dat) begin n_bad++; $display("FAIL conf_wr_keeps_dat: got %h want %h", dat_o, m_dat); end
    cyc(1'b1, 1'b0, PORT_CONF, 8'h00);
    n_cmp++; if (dat_o !== 8'h3F) begin n_bad++; $display("FAIL conf_rd: got %h want 3f", dat_o); end
  endtask

  task automatic test_loopback();
    loop_en = 1'b1;
    cyc(1'b1, 1'b1, PORT_STATUS, 8'hFF);
    n_cmp++; if (ch_out !== 6'h3F) begin n_bad++; $display("FAIL loop_out: got %h want 3f", ch_out); end
    repeat (2) cyc(1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, PORT_STATUS, 8'h00);
    n_cmp++; if (dat_o !== 8'h3F) begin n_bad++; $display("FAIL loop_status: got %h want 3f", dat_o); end
    n_cmp++; if (dat_o !== m_dat) begin n_bad++; $display("FAIL loop_status_model: got %h want %h", dat_o, m_dat); end
    loop_en = 1'b0;
  endtask

  task automatic test_pin_conf();
    logic [DATA_W-1:0] vals [NCH];
    vals = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
    cyc(1'b1, 1'b1, PORT_STATUS, DATA_W'($urandom));
    for (int n = 0; n < NCH; n++) cyc(1'b1, 1'b1, ADDR_W'(int'(PORT_PIN0_CONF) + n), vals[n]);
    for (int n = 0; n < NCH; n++) begin
      cyc(1'b1, 1'b0, ADDR_W'(int'(PORT_PIN0_CONF) + n), 8'h00);
      n_cmp++; if (dat_o !== vals[n]) begin n_bad++; $display("FAIL pin_rd[%0d]: got %h want %h", n, dat_o, vals[n]); end
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, '0, '0);
      n_cmp++; if (ch_out[1] !== clka) begin n_bad++; $display("FAIL pin1_clka: got %b want %b", ch_out[1], clka); end
      n_cmp++; if (ch_out[2] !== clkc) begin n_bad++; $display("FAIL pin2_clkc: got %b want %b", ch_out[2], clkc); end
      n_cmp++; if (ch_out !== exp_out()) begin n_bad++; $display("FAIL pin_out: got %h want %h", ch_out, exp_out()); end
    end
  endtask

  task automatic test_masking();
    cyc(1'b1, 1'b1, PORT_PIN0_CONF, 8'hFF);
    cyc(1'b1, 1'b0, PORT_PIN0_CONF, 8'h00);
    n_cmp++; if (dat_o !== 8'h1F) begin n_bad++; $display("FAIL pin0_mask: got %h want 1f", dat_o); end
    cyc(1'b1, 1'b1, 5'h1F, 8'hFF);
    n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL unmap_wr_ack: got %b want 1", ack_o); end
    cyc(1'b1, 1'b0, 5'h1F, 8'h00);
    n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL unmap_rd_ack: got %b want 1", ack_o); end
    n_cmp++; if (dat_o !== 8'h00) begin n_bad++; $display("FAIL unmap_rd: got %h want 00", dat_o); end
    for (int a = 0; a < 8; a++) begin
      if (a == 1) continue;
      cyc(1'b1, 1'b0, ADDR_W'(a), 8'h00);
      n_cmp++; if (dat_o !== model_read(ADDR_W'(a))) begin n_bad++; $display("FAIL unmap_no_change[%0d]: got %h want %h", a, dat_o, model_read(ADDR_W'(a))); end
    end
  endtask

  task automatic test_back_to_back();
    logic              stb, we, prev_wr;
    logic [ADDR_W-1:0] a, prev_a;
    prev_wr = 1'b0; prev_a = '0;
    rand_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      stb = ($urandom_range(0, 7) != 0);
      we  = $urandom_range(0, 1) == 1;
      a   = ($urandom_range(0, 4) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      if (prev_wr && $urandom_range(0, 1) == 1) begin stb = 1'b1; we = 1'b0; a = prev_a; end
      cyc(stb, we, a, DATA_W'($urandom));
      prev_wr = stb && we; prev_a = a;
      n_cmp++; if (ack_o !== m_ack) begin n_bad++; $display("FAIL b2b_ack[%0d]: got %b want %b", i, ack_o, m_ack); end
      n_cmp++; if (dat_o !== m_dat) begin n_bad++; $display("FAIL b2b_dat[%0d] adr=%h: got %h want %h", i, a, dat_o, m_dat); end
      n_cmp++; if (ch_oe !== m_conf) begin n_bad++; $display("FAIL b2b_oe[%0d]: got %h want %h", i, ch_oe, m_conf); end
      n_cmp++; if (ch_out !== exp_out()) begin n_bad++; $display("FAIL b2b_out[%0d]: got %h want %h", i, ch_out, exp_out()); end
    end
    rand_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b1, PORT_CONF, 8'h2A);
    cyc(1'b1, 1'b1, PORT_STATUS, 8'h3F);
    cyc(1'b1, 1'b0, PORT_CONF, 8'h00);
    n_cmp++; if (dat_o !== 8'h2A) begin n_bad++; $display("FAIL pre_rst_dat: got %h want 2a", dat_o); end
    rst_i = 1'b0;
    cyc(1'b1, 1'b1, PORT_CONF, 8'hFF);
    n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ack: got %b want 0", ack_o); end
    n_cmp++; if (ch_oe !== 6'h00) begin n_bad++; $display("FAIL rst_mid_oe: got %h want 00", ch_oe); end
    n_cmp++; if (ch_out !== 6'h00) begin n_bad++; $display("FAIL rst_mid_out: got %h want 00", ch_out); end
    n_cmp++; if (dat_o !== 8'h00) begin n_bad++; $display("FAIL rst_mid_dat: got %h want 00", dat_o); end
    rst_i = 1'b1; ch_in_drv = '0;
    for (int a = 0; a < 8; a++) begin
      cyc(1'b1, 1'b0, ADDR_W'(a), 8'h00);
      n_cmp++; if (dat_o !== 8'h00) begin n_bad++; $display("FAIL rst_mid_rd[%0d]: got %h want 00", a, dat_o); end
    end
  endtask

  initial begin
    test_reset();
    test_conf();
    test_loopback();
    test_pin_conf();
    test_masking();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
